// File: rtl/gfx_palette_server_if.sv
// Palette server bus bundle: evaluator read ports plus CPU write port.
// master = evaluator/CPU side, slave = palette server.
interface gfx_palette_server_if;
    logic [31:0] gfx_palette_bg_addr;
    logic [31:0] gfx_palette_obj_addr;
    logic [31:0] gfx_palette_bg_data;
    logic [31:0] gfx_palette_obj_data;
    logic        cpu_lock;
    logic        cpu_wr_valid;
    logic        cpu_wr_ready;
    logic [31:0] cpu_wr_addr;
    logic [31:0] cpu_wr_data;
    logic [1:0]  cpu_wr_size;
    logic        wbuf_empty;

    modport master (
        output gfx_palette_bg_addr, gfx_palette_obj_addr,
        output cpu_lock, cpu_wr_valid, cpu_wr_addr,
        output cpu_wr_data, cpu_wr_size,
        input  gfx_palette_bg_data, gfx_palette_obj_data,
        input  cpu_wr_ready, wbuf_empty
    );

    modport slave (
        input  gfx_palette_bg_addr, gfx_palette_obj_addr,
        input  cpu_lock, cpu_wr_valid, cpu_wr_addr,
        input  cpu_wr_data, cpu_wr_size,
        output gfx_palette_bg_data, gfx_palette_obj_data,
        output cpu_wr_ready, wbuf_empty
    );
endinterface

// File: rtl/gfx_palette_server.sv
// Palette RAM (BG + OBJ, 256 x 32) with CPU write buffer held off by cpu_lock.
// Optional macro PALETTE_WR_BYPASS_EN forwards the committing word to reads.
module gfx_palette_server #(
    parameter int WBUF_DEPTH = 2
) (
    input logic                 clock,
    input logic                 reset,
    gfx_palette_server_if.slave bus
);
    localparam int PW = (WBUF_DEPTH > 1) ? $clog2(WBUF_DEPTH) : 1;
    localparam int CW = $clog2(WBUF_DEPTH + 1);

    typedef struct packed {
        logic [7:0]  idx;
        logic [3:0]  be;
        logic [31:0] data;
    } went_t;

    logic [31:0]   mem_q [256];
    went_t         fifo_q [WBUF_DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          empty_q;
    logic [31:0]   bg_q, bg_d, obj_q, obj_d;
    logic          push, pop, ready;
    went_t         in_ent, head;
    logic [7:0]    lane_b;
    logic [7:0]    bg_idx, obj_idx;

    function automatic logic [31:0] merge(
        input logic [31:0] old,
        input logic [3:0]  be,
        input logic [31:0] data
    );
        logic [31:0] r;
        for (int i = 0; i < 4; i++) begin
            r[i*8 +: 8] = be[i] ? data[i*8 +: 8] : old[i*8 +: 8];
        end
        return r;
    endfunction

    assign ready   = cnt_q < CW'(WBUF_DEPTH);
    assign push    = bus.cpu_wr_valid && ready;
    assign pop     = (cnt_q != '0) && !bus.cpu_lock;
    assign head    = fifo_q[rd_ptr_q];
    assign cnt_d   = cnt_q + CW'(push) - CW'(pop);
    assign bg_idx  = bus.gfx_palette_bg_addr[9:2];
    assign obj_idx = bus.gfx_palette_obj_addr[9:2];

    assign bus.cpu_wr_ready         = ready;
    assign bus.wbuf_empty           = empty_q;
    assign bus.gfx_palette_bg_data  = bg_q;
    assign bus.gfx_palette_obj_data = obj_q;

    // Convert a CPU write into word index, byte enables and lane data
    always_comb begin
        lane_b      = bus.cpu_wr_data[{bus.cpu_wr_addr[1:0], 3'b000} +: 8];
        in_ent.idx  = bus.cpu_wr_addr[9:2];
        in_ent.be   = 4'b1111;
        in_ent.data = bus.cpu_wr_data;
        unique case (bus.cpu_wr_size)
            2'b00: begin
                in_ent.be   = bus.cpu_wr_addr[1] ? 4'b1100 : 4'b0011;
                in_ent.data = {4{lane_b}};
            end
            2'b01: begin
                in_ent.be = bus.cpu_wr_addr[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                in_ent.be = 4'b1111;
            end
        endcase
    end

    // Read ports; forwarding of the committing word is optional
    always_comb begin
        bg_d  = mem_q[bg_idx];
        obj_d = mem_q[obj_idx];
`ifdef PALETTE_WR_BYPASS_EN
        if (pop && bg_idx == head.idx) begin
            bg_d = merge(mem_q[head.idx], head.be, head.data);
        end
        if (pop && obj_idx == head.idx) begin
            obj_d = merge(mem_q[head.idx], head.be, head.data);
        end
`endif
    end

    // Palette array and buffer payload: no reset so they map to RAM
    always_ff @(posedge clock) begin
        if (push) begin
            fifo_q[wr_ptr_q] <= in_ent;
        end
        if (pop) begin
            for (int i = 0; i < 4; i++) begin
                if (head.be[i]) begin
                    mem_q[head.idx][i*8 +: 8] <= head.data[i*8 +: 8];
                end
            end
        end
    end

    // Buffer control state and registered read data
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            empty_q  <= 1'b1;
            bg_q     <= '0;
            obj_q    <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
            cnt_q   <= cnt_d;
            empty_q <= (cnt_d == '0);
            bg_q    <= bg_d;
            obj_q   <= obj_d;
        end
    end
endmodule

// File: tb/tb_gfx_palette_server.sv
// Directed bench for gfx_palette_server with read-result scoreboard.
// Build with +define+PALETTE_WR_BYPASS_EN to cover the forwarding path.
module tb_gfx_palette_server;
    logic clock = 1'b0;
    logic reset = 1'b0;
    int   vecs  = 0;
    int   errs  = 0;

    logic [31:0] exp_q [$];
    string       tag_q [$];
    bit          port_q [$];

    gfx_palette_server_if bus ();

    gfx_palette_server #(.WBUF_DEPTH(2)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        vecs++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d,
                      input logic [1:0] s);
        int n = 0;
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = a;
        bus.cpu_wr_data  = d;
        bus.cpu_wr_size  = s;
        while (!bus.cpu_wr_ready && n < 50) begin
            idle(1);
            n++;
        end
        if (n == 50) chk("wr_timeout", 32'd0, 32'd1);
        idle(1);
        bus.cpu_wr_valid = 1'b0;
    endtask

    // port 0 = BG, 1 = OBJ; result checked one edge later
    task automatic rd(input bit port, input logic [31:0] a,
                      input logic [31:0] exp, input string tag);
        logic [31:0] e;
        string       t;
        bit          p;
        if (port) bus.gfx_palette_obj_addr = a;
        else      bus.gfx_palette_bg_addr  = a;
        exp_q.push_back(exp);
        tag_q.push_back(tag);
        port_q.push_back(port);
        idle(1);
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        p = port_q.pop_front();
        chk(t, p ? bus.gfx_palette_obj_data : bus.gfx_palette_bg_data, e);
    endtask

    initial begin
        bus.gfx_palette_bg_addr  = '0;
        bus.gfx_palette_obj_addr = '0;
        bus.cpu_lock             = 1'b0;
        bus.cpu_wr_valid         = 1'b0;
        bus.cpu_wr_addr          = '0;
        bus.cpu_wr_data          = '0;
        bus.cpu_wr_size          = 2'b10;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_bg", bus.gfx_palette_bg_data, 32'h0);
        chk("rst_obj", bus.gfx_palette_obj_data, 32'h0);
        chk("rst_ready", 32'(bus.cpu_wr_ready), 32'd1);
        chk("rst_empty", 32'(bus.wbuf_empty), 32'd1);
        reset = 1'b1;
        idle(1);

        // word write, visible two edges after acceptance
        bus.gfx_palette_bg_addr = 32'h0500_0000;
        wr(32'h0500_0000, 32'h7FFF_001F, 2'b10);
        idle(1);
        rd(0, 32'h0500_0000, 32'h7FFF_001F, "word_wr");

        // back-to-back word then upper-half write
        wr(32'h0500_0200, 32'h1122_3344, 2'b10);
        wr(32'h0500_0202, 32'h03E0_0000, 2'b01);
        idle(1);
        rd(1, 32'h0500_0200, 32'h03E0_3344, "half_wr");

        // byte writes duplicate into the selected halfword
        wr(32'h0500_0010, 32'hDEAD_BEEF, 2'b10);
        wr(32'h0500_0011, 32'h5566_AB77, 2'b00);
        idle(1);
        rd(0, 32'h0500_0010, 32'hDEAD_ABAB, "byte_lo");
        wr(32'h0500_0013, 32'hC100_0000, 2'b00);
        idle(1);
        rd(0, 32'h0500_0010, 32'hC1C1_ABAB, "byte_hi");

        // size 11 acts as word; high address bits ignored
        wr(32'h0500_000D, 32'h0FF0_0FF0, 2'b11);
        idle(1);
        rd(1, 32'h0500_000C, 32'h0FF0_0FF0, "size3");
        rd(0, 32'hFFFF_FC0C, 32'h0FF0_0FF0, "alias");

        // lock holds writes; full buffer refuses the third
        bus.cpu_lock = 1'b1;
        wr(32'h0500_0028, 32'hAAAA_0001, 2'b10);
        wr(32'h0500_0028, 32'hBBBB_0002, 2'b10);
        chk("full_ready", 32'(bus.cpu_wr_ready), 32'd0);
        chk("full_empty", 32'(bus.wbuf_empty), 32'd0);
        bus.cpu_wr_valid = 1'b1;
        bus.cpu_wr_addr  = 32'h0500_002C;
        bus.cpu_wr_data  = 32'hCCCC_0003;
        bus.cpu_wr_size  = 2'b10;
        idle(2);
        chk("held_ready", 32'(bus.cpu_wr_ready), 32'd0);
        bus.cpu_lock = 1'b0;
        idle(1);
        chk("pop_no_push", 32'(bus.cpu_wr_ready), 32'd1);
        idle(1);
        bus.cpu_wr_valid = 1'b0;
        chk("drain_empty0", 32'(bus.wbuf_empty), 32'd0);
        idle(1);
        chk("drain_empty1", 32'(bus.wbuf_empty), 32'd1);
        rd(0, 32'h0500_0028, 32'hBBBB_0002, "order");
        rd(1, 32'h0500_002C, 32'hCCCC_0003, "third_wr");

        // read of the committing word in the same cycle
        wr(32'h0500_0014, 32'hAAAA_5555, 2'b10);
        idle(1);
        bus.gfx_palette_bg_addr = 32'h0500_0014;
        wr(32'h0500_0014, 32'h1234_5678, 2'b10);
`ifdef PALETTE_WR_BYPASS_EN
        rd(0, 32'h0500_0014, 32'h1234_5678, "rdw_word");
`else
        rd(0, 32'h0500_0014, 32'hAAAA_5555, "rdw_word");
`endif
        rd(0, 32'h0500_0014, 32'h1234_5678, "after_word");
        wr(32'h0500_0016, 32'hBEEF_0000, 2'b01);
`ifdef PALETTE_WR_BYPASS_EN
        rd(0, 32'h0500_0014, 32'hBEEF_5678, "rdw_half");
`else
        rd(0, 32'h0500_0014, 32'h1234_5678, "rdw_half");
`endif
        rd(0, 32'h0500_0014, 32'hBEEF_5678, "after_half");

        // reset discards pending writes, array keeps contents
        wr(32'h0500_0050, 32'h0101_0101, 2'b10);
        wr(32'h0500_0054, 32'h0202_0202, 2'b10);
        idle(2);
        bus.cpu_lock = 1'b1;
        wr(32'h0500_0050, 32'h9999_9999, 2'b10);
        wr(32'h0500_0054, 32'h8888_8888, 2'b10);
        reset = 1'b0;
        #1;
        chk("mid_rst_bg", bus.gfx_palette_bg_data, 32'h0);
        chk("mid_rst_obj", bus.gfx_palette_obj_data, 32'h0);
        chk("mid_rst_ready", 32'(bus.cpu_wr_ready), 32'd1);
        chk("mid_rst_empty", 32'(bus.wbuf_empty), 32'd1);
        idle(1);
        reset = 1'b1;
        bus.cpu_lock = 1'b0;
        idle(2);
        chk("post_rst_empty", 32'(bus.wbuf_empty), 32'd1);
        rd(0, 32'h0500_0050, 32'h0101_0101, "kept_20");
        rd(1, 32'h0500_0054, 32'h0202_0202, "kept_21");

        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end
endmodule

// File: doc/gfx_palette_server.md
# gfx_palette_server

Palette RAM responder for the graphics pipeline. It holds the 512-byte BG palette and the 512-byte OBJ palette as one 256 x 32-bit word array and answers the priority evaluator's BG and OBJ palette address ports with registered 32-bit data. It also accepts CPU palette writes through a 2-entry write buffer. The buffer holds writes back while the CPU is locked out during active rendering.

## Interface
- `WBUF_DEPTH`, default 2: CPU write buffer entries; legal values are 2 and 4.
- `clock` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `gfx_palette_bg_addr` input 32: BG read byte address; bits [9:2] select the word.
- `gfx_palette_obj_addr` input 32: OBJ read byte address; bits [9:2] select the word.
- `gfx_palette_bg_data` output 32: registered word for the previous cycle's BG address.
- `gfx_palette_obj_data` output 32: registered word for the previous cycle's OBJ address.
- `cpu_lock` input 1: 1 = rendering active; buffered writes are held, not committed.
- `cpu_wr_valid` input 1: CPU write request.
- `cpu_wr_ready` output 1: write buffer not full.
- `cpu_wr_addr` input 32: write byte address; bits [9:0] are used.
- `cpu_wr_data` input 32: write data, lane-aligned as on the bus.
- `cpu_wr_size` input 2: 00 = byte, 01 = half, 10 = word; 11 is treated as word.
- `wbuf_empty` output 1: write buffer empty; all writes committed.

## Operation
- Array index is `addr[9:2]`. Indices 0–127 are BG and 128–255 are OBJ. Address bits [31:10] are ignored.
- Either read port may address any index. The `addr[9]` select is the requester's responsibility.
- Reads are unconditional every cycle, with no enable.
- Write acceptance: a write is enqueued when `cpu_wr_valid && cpu_wr_ready`. The FIFO keeps write order.
- Commit: when the buffer is non-empty and `cpu_lock == 0`, the head entry is committed and popped, one entry per cycle.
- Word write: all 4 bytes are written; `addr[1:0]` is ignored.
- Half write: `addr[1]` selects the halfword. The data comes from the matching lane of `cpu_wr_data`.
- Byte write: the addressed byte, taken from lane `addr[1:0]`, is duplicated into both bytes of the halfword selected by `addr[1]`. This is GBA palette byte-write semantics.
- Simultaneous enqueue and commit with the buffer full: `cpu_wr_ready` is computed from the current count, so the write is not accepted that cycle.
- `cpu_lock` rising mid-drain: the next commit is held; entries already committed stay committed.
- Reset: buffer pointers and count are cleared; pending writes are discarded.
- Reset outputs: `gfx_palette_*_data` = 0, `cpu_wr_ready` = 1, `wbuf_empty` = 1.
- Array contents are not reset (BRAM-inferable).

## Timing
- Read latency is 1 cycle: the address sampled at edge N appears on the data output after edge N.
- Read-during-commit to the same word: the output shows the pre-write word. With `PALETTE_WR_BYPASS_EN`, it shows the post-write word (see Configuration).
- Write latency with `cpu_lock` low: accepted at edge N, committed at edge N+1, visible on the read outputs at edge N+2 for an address held at N+1.
- Back-to-back writes sustain 1 per cycle with `cpu_lock` low.
- `wbuf_empty` is registered. It rises on the edge that pops the last entry, unless a new write is accepted on the same edge.

## Configuration
- `PALETTE_WR_BYPASS_EN` defined:
  - Each read port compares its word index against the committing entry's index.
  - On a match, the registered output takes the merged post-write word, with the byte merge applied.
- Undefined:
  - No forwarding; a same-cycle read returns the old word.
  - Zero extra comparators.

## Test plan
- Reset, then `cpu_lock` = 0; write word 0x7FFF_001F to 0x0500_0000; BG addr 0x0500_0000 -> `gfx_palette_bg_data` = 0x7FFF_001F two cycles after acceptance.
- Write half 0x03E0 at 0x0500_0202, then OBJ read of 0x0500_0200 -> upper half = 0x03E0, lower half unchanged.
- Byte write 0xAB at 0x0500_0011 (lane 1) -> word 4 bits [15:0] = 0xABAB, bits [31:16] unchanged.
- Hold `cpu_lock` = 1 and issue 3 writes -> `cpu_wr_ready` falls after 2 accepts. Release the lock -> commits in order on consecutive cycles and `wbuf_empty` rises.
- Commit 0x1234_5678 to index 5 while BG reads index 5 in the same cycle -> old word without the macro, 0x1234_5678 with `PALETTE_WR_BYPASS_EN`.
- Assert `reset` low with 2 writes pending -> buffer empty, outputs 0, and the array at those indices is unchanged after release.
